// File: rtl/cpu_wb_pkg.sv
// Shared types for the writeback queue: register index/data widths and the queued entry.
package cpu_wb_pkg;

    localparam int REG_IDX_W = 4;
    localparam int REG_W     = 32;

    typedef struct packed {
        logic [REG_IDX_W-1:0] index;
        logic [REG_W-1:0]     value;
    } entry_t;

endpackage

// File: rtl/cpu_wb_match.sv
// Compares every occupied queue entry against one decode read index; reports a hit and,
// when CPU_WB_FORWARD_EN is defined, forwards the data of the youngest matching entry.
module cpu_wb_match
    import cpu_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  entry_t [DEPTH-1:0]   entries,
    input  logic [PTR_W-1:0]     head,
    input  logic [CNT_W-1:0]     count,
    input  logic [REG_IDX_W-1:0] read_index,
    output logic                 pending,
    output logic [REG_W-1:0]     fwd_value
);

    logic [DEPTH-1:0] hit;
    logic [PTR_W-1:0] pos [DEPTH];

    // hit[age] is ordered oldest (age 0 = head) to youngest.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        assign pos[gi] = head + PTR_W'(gi);
        assign hit[gi] = (CNT_W'(gi) < count) && (entries[pos[gi]].index == read_index);
    end

    assign pending = |hit;

`ifdef CPU_WB_FORWARD_EN
    always_comb begin
        fwd_value = '0;
        for (int a = 0; a < DEPTH; a++) begin
            if (hit[a]) begin
                fwd_value = entries[pos[a]].value;
            end
        end
    end
`else
    logic unused_entry_bits;
    assign unused_entry_bits = ^entries;
    assign fwd_value = '0;
`endif

endmodule

// File: rtl/cpu_writeback_queue.sv
// Two-port writeback queue between execute/load results and the register file.
// Optional forwarding of queued data is enabled by defining CPU_WB_FORWARD_EN.
module cpu_writeback_queue
    import cpu_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ex_valid_i,
    output logic                          ex_ready_o,
    input  logic [3:0]                    ex_index_i,
    input  logic [31:0]                   ex_value_i,
    input  logic                          ld_valid_i,
    output logic                          ld_ready_o,
    input  logic [3:0]                    ld_index_i,
    input  logic [31:0]                   ld_value_i,
    output logic                          write_enable0_o,
    output logic                          write_enable1_o,
    output logic [3:0]                    reg_write_index0_o,
    output logic [3:0]                    reg_write_index1_o,
    output logic [31:0]                   value0_o,
    output logic [31:0]                   value1_o,
    input  logic [3:0]                    reg_read_index0_i,
    input  logic [3:0]                    reg_read_index1_i,
    output logic                          pending0_o,
    output logic                          pending1_o,
    output logic [31:0]                   fwd_value0_o,
    output logic [31:0]                   fwd_value1_o,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t [DEPTH-1:0] entries_reg;
    logic [PTR_W-1:0]   head_reg;
    logic [PTR_W-1:0]   tail_reg;
    logic [CNT_W-1:0]   count_reg;

    logic [CNT_W-1:0]   count_next;
    logic [CNT_W-1:0]   occ;
    logic [PTR_W-1:0]   head_plus1;
    logic [PTR_W-1:0]   ld_slot;
    entry_t             head_entry;
    entry_t             second_entry;
    logic               ex_fire;
    logic               ld_fire;
    logic [1:0]         enq;
    logic [1:0]         deq;

    // Reset masks every occupancy-derived output immediately, not just after the edge.
    assign occ        = rst_i ? '0 : count_reg;
    assign ex_ready_o = !rst_i && (count_reg < CNT_W'(DEPTH));
    assign ld_ready_o = !rst_i && (count_reg <= CNT_W'(DEPTH - 2));
    assign ex_fire    = ex_valid_i && ex_ready_o;
    assign ld_fire    = ld_valid_i && ld_ready_o;

    assign head_plus1   = head_reg + PTR_W'(1);
    assign head_entry   = entries_reg[head_reg];
    assign second_entry = entries_reg[head_plus1];

    // A same-index younger entry waits one cycle so the register file sees program order.
    assign write_enable0_o    = (occ != '0);
    assign write_enable1_o    = (occ >= CNT_W'(2)) && (second_entry.index != head_entry.index);
    assign reg_write_index0_o = head_entry.index;
    assign value0_o           = head_entry.value;
    assign reg_write_index1_o = second_entry.index;
    assign value1_o           = second_entry.value;

    assign enq        = {1'b0, ex_fire} + {1'b0, ld_fire};
    assign deq        = {1'b0, write_enable0_o} + {1'b0, write_enable1_o};
    assign count_next = count_reg + CNT_W'(enq) - CNT_W'(deq);
    assign ld_slot    = ex_fire ? tail_reg + PTR_W'(1) : tail_reg;
    assign count_o    = occ;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_reg + PTR_W'(deq);
            tail_reg  <= tail_reg + PTR_W'(enq);
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ex_fire) begin
            entries_reg[tail_reg] <= {ex_index_i, ex_value_i};
        end
        if (ld_fire) begin
            entries_reg[ld_slot] <= {ld_index_i, ld_value_i};
        end
    end

    logic [REG_IDX_W-1:0] read_index [2];
    logic                 pending    [2];
    logic [REG_W-1:0]     fwd_value  [2];

    assign read_index[0] = reg_read_index0_i;
    assign read_index[1] = reg_read_index1_i;

    for (genvar gi = 0; gi < 2; gi++) begin : g_match
        cpu_wb_match #(.DEPTH(DEPTH)) u_match (
            .entries    (entries_reg),
            .head       (head_reg),
            .count      (occ),
            .read_index (read_index[gi]),
            .pending    (pending[gi]),
            .fwd_value  (fwd_value[gi])
        );
    end

    assign pending0_o   = pending[0];
    assign pending1_o   = pending[1];
    assign fwd_value0_o = fwd_value[0];
    assign fwd_value1_o = fwd_value[1];

endmodule

// File: tb/tb_cpu_writeback_queue.sv
// Scoreboard bench for cpu_writeback_queue: directed stimulus pushes expected writes,
// a negedge monitor pops them as the register-file ports fire. Honours CPU_WB_FORWARD_EN.
module tb_cpu_writeback_queue;
    import cpu_wb_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i, ld_valid_i;
    logic        ex_ready_o, ld_ready_o;
    logic [3:0]  ex_index_i, ld_index_i;
    logic [31:0] ex_value_i, ld_value_i;
    logic        write_enable0_o, write_enable1_o;
    logic [3:0]  reg_write_index0_o, reg_write_index1_o;
    logic [31:0] value0_o, value1_o;
    logic [3:0]  reg_read_index0_i, reg_read_index1_i;
    logic        pending0_o, pending1_o;
    logic [31:0] fwd_value0_o, fwd_value1_o;
    logic [2:0]  count_o;

    int vectors = 0;
    int miscompares = 0;
    entry_t exp_q[$];
    logic [31:0] fwd_exp;

    cpu_writeback_queue #(.DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .ex_index_i(ex_index_i), .ex_value_i(ex_value_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
        .ld_index_i(ld_index_i), .ld_value_i(ld_value_i),
        .write_enable0_o(write_enable0_o), .write_enable1_o(write_enable1_o),
        .reg_write_index0_o(reg_write_index0_o), .reg_write_index1_o(reg_write_index1_o),
        .value0_o(value0_o), .value1_o(value1_o),
        .reg_read_index0_i(reg_read_index0_i), .reg_read_index1_i(reg_read_index1_i),
        .pending0_o(pending0_o), .pending1_o(pending1_o),
        .fwd_value0_o(fwd_value0_o), .fwd_value1_o(fwd_value1_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input int port, input logic [3:0] idx, input logic [31:0] val);
        entry_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: port%0d r%0d = 0x%0h with empty scoreboard", port, idx, val);
        end else begin
            e = exp_q.pop_front();
            $display("wb port%0d r%0d = 0x%0h (expected r%0d = 0x%0h)", port, idx, val, e.index, e.value);
            check($sformatf("wb_port%0d_index", port), {28'd0, idx}, {28'd0, e.index});
            check($sformatf("wb_port%0d_value", port), val, e.value);
        end
    endtask

    // Monitor: port0 is always older than port1 in the same cycle.
    always @(negedge clk_i) begin
        if (write_enable0_o === 1'b1) pop_cmp(0, reg_write_index0_o, value0_o);
        if (write_enable1_o === 1'b1) pop_cmp(1, reg_write_index1_o, value1_o);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_ex(input logic [3:0] idx, input logic [31:0] val, input bit expect_accept);
        ex_valid_i = 1'b1; ex_index_i = idx; ex_value_i = val;
        if (expect_accept) exp_q.push_back({idx, val});
    endtask

    task automatic drive_ld(input logic [3:0] idx, input logic [31:0] val, input bit expect_accept);
        ld_valid_i = 1'b1; ld_index_i = idx; ld_value_i = val;
        if (expect_accept) exp_q.push_back({idx, val});
    endtask

    task automatic idle();
        ex_valid_i = 1'b0;
        ld_valid_i = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (count_o != 3'd0 && n < budget) begin
            tick();
            n++;
        end
        check(name, {29'd0, count_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        idle();
        ex_index_i = '0; ex_value_i = '0; ld_index_i = '0; ld_value_i = '0;
        reg_read_index0_i = 4'd0; reg_read_index1_i = 4'd0;
        tick(); tick();
        check("rst_count", {29'd0, count_o}, 32'd0);
        check("rst_ex_ready", {31'd0, ex_ready_o}, 32'd0);
        check("rst_ld_ready", {31'd0, ld_ready_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        check("post_rst_ex_ready", {31'd0, ex_ready_o}, 32'd1);
        check("post_rst_ld_ready", {31'd0, ld_ready_o}, 32'd1);
        check("post_rst_we0", {31'd0, write_enable0_o}, 32'd0);
        check("post_rst_pending0", {31'd0, pending0_o}, 32'd0);

        // Single ex write.
        drive_ex(4'd3, 32'h11, 1'b1);
        tick(); idle(); #1;
        check("single_we0", {31'd0, write_enable0_o}, 32'd1);
        check("single_we1", {31'd0, write_enable1_o}, 32'd0);
        check("single_count", {29'd0, count_o}, 32'd1);
        tick();
        check("single_count_after", {29'd0, count_o}, 32'd0);

        // ex and ld in one cycle, different registers: both drain together.
        drive_ex(4'd2, 32'hA, 1'b1);
        drive_ld(4'd5, 32'hB, 1'b1);
        tick(); idle(); #1;
        check("dual_we0", {31'd0, write_enable0_o}, 32'd1);
        check("dual_we1", {31'd0, write_enable1_o}, 32'd1);
        tick();
        check("dual_count_after", {29'd0, count_o}, 32'd0);

        // Same register twice: serialised drain, pending held until the younger retires.
        reg_read_index0_i = 4'd4;
        drive_ex(4'd4, 32'h1, 1'b1);
        drive_ld(4'd4, 32'h2, 1'b1);
        tick(); idle(); #1;
        check("same_c1_count", {29'd0, count_o}, 32'd2);
        check("same_c1_we1", {31'd0, write_enable1_o}, 32'd0);
        check("same_c1_pending", {31'd0, pending0_o}, 32'd1);
        tick();
        check("same_c2_we0", {31'd0, write_enable0_o}, 32'd1);
        check("same_c2_pending", {31'd0, pending0_o}, 32'd1);
        tick();
        check("same_c3_pending", {31'd0, pending0_o}, 32'd0);

        // Fill with same-index entries across pointer wrap; rejected ld must not enqueue.
        drive_ex(4'd6, 32'h1, 1'b1);
        drive_ld(4'd6, 32'h2, 1'b1);
        tick();
        check("fill_c1_count", {29'd0, count_o}, 32'd2);
        check("fill_c1_ld_ready", {31'd0, ld_ready_o}, 32'd1);
        drive_ex(4'd6, 32'h3, 1'b1);
        drive_ld(4'd6, 32'h4, 1'b1);
        tick();
        check("fill_c2_count", {29'd0, count_o}, 32'd3);
        check("fill_c2_ld_ready", {31'd0, ld_ready_o}, 32'd0);
        check("fill_c2_ex_ready", {31'd0, ex_ready_o}, 32'd1);
        drive_ex(4'd6, 32'h5, 1'b1);
        drive_ld(4'd6, 32'h99, 1'b0);
        tick();
        check("fill_c3_count", {29'd0, count_o}, 32'd3);
        drive_ex(4'd6, 32'h6, 1'b1);
        tick(); idle();
        check("fill_c4_count", {29'd0, count_o}, 32'd3);
        wait_empty("fill_drain_done", 10);
        check("fill_scoreboard_empty", exp_q.size(), 32'd0);

        // Reset with three entries queued; incoming ex during reset is ignored.
        drive_ex(4'd8, 32'h21, 1'b1);
        drive_ld(4'd8, 32'h22, 1'b1);
        tick();
        drive_ex(4'd8, 32'h23, 1'b1);
        drive_ld(4'd8, 32'h24, 1'b1);
        tick(); idle();
        check("prerst_count", {29'd0, count_o}, 32'd3);
        reg_read_index0_i = 4'd8;
        rst_i = 1'b1;
        drive_ex(4'd9, 32'hDEAD, 1'b0);
        #1;
        check("inrst_count", {29'd0, count_o}, 32'd0);
        check("inrst_we0", {31'd0, write_enable0_o}, 32'd0);
        check("inrst_ex_ready", {31'd0, ex_ready_o}, 32'd0);
        check("inrst_pending0", {31'd0, pending0_o}, 32'd0);
        tick();
        rst_i = 1'b0; idle(); #1;
        check("postrst_count", {29'd0, count_o}, 32'd0);
        check("postrst_we0", {31'd0, write_enable0_o}, 32'd0);
        check("postrst_ld_ready", {31'd0, ld_ready_o}, 32'd1);
        check("postrst_discarded", exp_q.size(), 32'd3);
        exp_q.delete();
        tick();
        check("postrst_idle_count", {29'd0, count_o}, 32'd0);

        // Forwarding: youngest match wins.
`ifdef CPU_WB_FORWARD_EN
        fwd_exp = 32'h9;
`else
        fwd_exp = 32'h0;
`endif
        reg_read_index0_i = 4'd7;
        reg_read_index1_i = 4'd3;
        drive_ex(4'd7, 32'h5, 1'b1);
        drive_ld(4'd7, 32'h9, 1'b1);
        tick(); idle(); #1;
        check("fwd_c1_pending0", {31'd0, pending0_o}, 32'd1);
        check("fwd_c1_value0", fwd_value0_o, fwd_exp);
        check("fwd_c1_pending1", {31'd0, pending1_o}, 32'd0);
        check("fwd_c1_value1", fwd_value1_o, 32'd0);
        tick();
        check("fwd_c2_pending0", {31'd0, pending0_o}, 32'd1);
        check("fwd_c2_value0", fwd_value0_o, fwd_exp);
        tick();
        check("fwd_c3_pending0", {31'd0, pending0_o}, 32'd0);
        check("fwd_c3_value0", fwd_value0_o, 32'd0);

        tick();
        check("final_scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
